cond_unit_mc: RTL and testbench
===============================

# cond_unit_mc

Multi-context condition unit for the pipelined ARM core's controller. It holds one NZCV flag register per hardware context and evaluates the full 16-code ARM condition field against the selected context's flags. Flag updates are gated by the condition result, and each context has a bounded flag save/restore stack for exception entry and return. It sits in the execute-stage control path, driving CondEx to the writeback-enable logic and taking ALU flags from the datapath.

## Interface
- NCTX, 2: number of flag contexts (≥1); CW = max(1, $clog2(NCTX))
- SDEPTH, 4: save-stack entries per context (≥1)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- Valid  in  1  an instruction is present in this stage
- Ctx  in  CW  context of the current instruction
- Cond  in  4  ARM condition field
- ALUFlags  in  4  {N,Z,C,V} produced by the ALU this cycle
- FlagWrite  in  2  [1] requests an NZ update, [0] requests a CV update
- ExcCtx  in  CW  context targeted by Save/Restore
- Save  in  1  push ExcCtx's current flags onto its stack
- Restore  in  1  pop ExcCtx's stack into its flag register
- CondEx  out  1  condition passed (combinational)
- FlagsOut  out  4  registered flags of Ctx (combinational read)
- StackFull  out  NCTX  per-context stack full
- StackEmpty  out  NCTX  per-context stack empty
- StackErr  out  1  registered one-cycle error pulse

## Operation
- State per context: flags_q (4b), stack of SDEPTH×4b, count (0..SDEPTH).
- Condition decode on flags_q[Ctx]: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1; 1111 is 0.
- CondEx = Valid & decode. If Valid=0, CondEx=0 and no flag write occurs.
- Instruction write: if CondEx, FlagWrite[1] loads ALUFlags[3:2] into flags_q[Ctx][3:2], and FlagWrite[0] loads ALUFlags[1:0] into flags_q[Ctx][1:0]. Unselected halves hold their value.
- Save: if count[ExcCtx] < SDEPTH, push flags_q[ExcCtx] (the pre-edge value) and increment count. An instruction write in the same cycle still applies.
- Restore: if count[ExcCtx] > 0, pop the top entry into flags_q[ExcCtx] and decrement count. The restore overrides any instruction write to the same context in that cycle. An instruction write to a different context still applies.
- Save and Restore asserted together: both are ignored and StackErr is raised.
- Save when full, or Restore when empty: the operation is ignored (no state change), StackErr is raised, and the instruction write still applies.
- StackErr is registered high in the cycle after an error and is low otherwise.
- Out-of-range Ctx or ExcCtx (≥NCTX): treated as invalid. CondEx=0, FlagsOut=0, no writes, and Save/Restore raise StackErr.
- StackFull[i] = (count[i]==SDEPTH) and StackEmpty[i] = (count[i]==0), both driven from registered counts.

## Timing
- CondEx and FlagsOut are combinational from the current-cycle inputs and registered state. Zero-cycle latency.
- Flag writes are visible on FlagsOut and in condition evaluation one cycle later. There is no same-cycle bypass; back-to-back dependent instructions are handled by the hazard unit.
- A restored value is visible the cycle after Restore. A pushed value is observable only through a later Restore.
- Reset: all flags_q=0, all counts=0, StackErr=0, StackEmpty=all ones, StackFull=0. Stack contents are don't-care.
- Reset asserted during any operation takes priority: that cycle's writes, pushes and pops are discarded.

## Test plan
- Reset then Valid=1, Ctx=0, Cond=0000 (EQ) → CondEx=0. Cond=1110 → CondEx=1. Cond=1111 → CondEx=0.
- Ctx=1, Cond=AL, FlagWrite=10, ALUFlags=0100 → next cycle FlagsOut(Ctx=1)=0100, Ctx=0 is still 0000, and EQ on Ctx=1 gives CondEx=1.
- Flags of ctx 0 = 0100, Cond=NE, FlagWrite=11, ALUFlags=1011 → CondEx=0 and flags stay 0100. Repeat with Cond=EQ → flags become 1011.
- Sweep all 16 Cond codes × 16 flag values on one context → CondEx matches the decode list exactly.
- ExcCtx=0: Save with flags 1010, overwrite to 0001, then Restore → FlagsOut=1010 and StackEmpty[0]=1. Save SDEPTH+1 times → StackFull[0]=1 after SDEPTH pushes, StackErr=1 one cycle after the extra push, and count is unchanged.
- Restore on an empty stack → StackErr pulse and flags unchanged. Save+Restore in the same cycle → StackErr and no change. Restore on ctx 0 alongside an AL write on ctx 0 → the restored value wins. Assert reset mid-sequence → every output returns to its reset value.

Source files
------------

// File: rtl/cond_unit_mc.sv
// cond_unit_mc
// Multi-context condition unit for the execute-stage controller. Each
// hardware context owns an NZCV flag register and a small flag save stack
// that is used on exception entry (Save) and exception return (Restore).
// The selected context's flags are decoded against the ARM condition field.
// The result (CondEx) gates writeback and gates this unit's own flag updates.
//
// Ports:
//   clk        clock; all state changes on the rising edge
//   reset      synchronous, active-high
//   Valid      an instruction is present in this stage
//   Ctx        context of the current instruction
//   Cond       ARM condition field
//   ALUFlags   {N,Z,C,V} produced by the ALU this cycle
//   FlagWrite  [1] requests an NZ update, [0] requests a CV update
//   ExcCtx     context targeted by Save/Restore
//   Save       push ExcCtx's current flags onto its stack
//   Restore    pop ExcCtx's stack into its flag register
//   CondEx     condition passed (combinational)
//   FlagsOut   registered flags of Ctx (combinational read)
//   StackFull  per-context stack full
//   StackEmpty per-context stack empty
//   StackErr   registered one-cycle error pulse
module cond_unit_mc #(
  parameter int NCTX   = 2,
  parameter int SDEPTH = 4,
  localparam int CW    = (NCTX > 1) ? $clog2(NCTX) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Valid,
  input  logic [CW-1:0]   Ctx,
  input  logic [3:0]      Cond,
  input  logic [3:0]      ALUFlags,
  input  logic [1:0]      FlagWrite,
  input  logic [CW-1:0]   ExcCtx,
  input  logic            Save,
  input  logic            Restore,
  output logic            CondEx,
  output logic [3:0]      FlagsOut,
  output logic [NCTX-1:0] StackFull,
  output logic [NCTX-1:0] StackEmpty,
  output logic            StackErr
);

  localparam int NW = $clog2(SDEPTH + 1);
  localparam int SW = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

  logic [3:0]    flags_q [NCTX];
  logic [3:0]    stack_q [NCTX][SDEPTH];
  logic [NW-1:0] count_q [NCTX];
  logic          err_q;

  logic          ctx_ok;
  logic          exc_ok;
  logic [3:0]    cur_flags;
  logic [3:0]    exc_flags;
  logic [NW-1:0] exc_count;
  logic [NW-1:0] exc_count_m1;
  logic [SW-1:0] push_idx;
  logic [SW-1:0] pop_idx;
  logic [3:0]    pop_val;
  logic          wr_en;
  logic          do_push;
  logic          do_pop;
  logic          err_d;

  // Full 16-entry ARM condition decode; code 1111 never passes.
  function automatic logic cond_decode(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_decode = z;
      4'b0001: cond_decode = ~z;
      4'b0010: cond_decode = cf;
      4'b0011: cond_decode = ~cf;
      4'b0100: cond_decode = n;
      4'b0101: cond_decode = ~n;
      4'b0110: cond_decode = v;
      4'b0111: cond_decode = ~v;
      4'b1000: cond_decode = cf & ~z;
      4'b1001: cond_decode = ~cf | z;
      4'b1010: cond_decode = (n == v);
      4'b1011: cond_decode = (n != v);
      4'b1100: cond_decode = ~z & (n == v);
      4'b1101: cond_decode = z | (n != v);
      4'b1110: cond_decode = 1'b1;
      default: cond_decode = 1'b0;
    endcase
  endfunction

  // Instruction side: an out-of-range context reads as zero flags and never passes.
  always_comb begin
    ctx_ok    = (int'(Ctx) < NCTX);
    cur_flags = ctx_ok ? flags_q[Ctx] : 4'b0000;
    CondEx    = Valid & ctx_ok & cond_decode(Cond, cur_flags);
    FlagsOut  = cur_flags;
    wr_en     = CondEx;
  end

  // Exception side: decide whether Save/Restore actually happens or becomes an error.
  // Save+Restore together is always an error, regardless of stack state.
  always_comb begin
    exc_ok       = (int'(ExcCtx) < NCTX);
    exc_flags    = exc_ok ? flags_q[ExcCtx] : 4'b0000;
    exc_count    = exc_ok ? count_q[ExcCtx] : '0;
    exc_count_m1 = exc_count - NW'(1);
    push_idx     = exc_count[SW-1:0];
    pop_idx      = exc_count_m1[SW-1:0];
    pop_val      = exc_ok ? stack_q[ExcCtx][pop_idx] : 4'b0000;
    do_push      = 1'b0;
    do_pop       = 1'b0;
    err_d        = 1'b0;
    if (Save && Restore) begin
      err_d = 1'b1;
    end else if (Save || Restore) begin
      if (!exc_ok) begin
        err_d = 1'b1;
      end else if (Save) begin
        if (exc_count == NW'(SDEPTH)) err_d = 1'b1;
        else                          do_push = 1'b1;
      end else begin
        if (exc_count == '0) err_d = 1'b1;
        else                 do_pop = 1'b1;
      end
    end
  end

  // Flag registers, stack counts and the error pulse. A pop into a context
  // wins over an instruction write to that same context; the push side reads
  // the pre-edge flags, so a same-cycle write still lands in the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
      for (int i = 0; i < NCTX; i++) begin
        flags_q[i] <= 4'b0000;
        count_q[i] <= '0;
      end
    end else begin
      err_q <= err_d;
      for (int i = 0; i < NCTX; i++) begin
        if (do_pop && (int'(ExcCtx) == i)) begin
          flags_q[i] <= pop_val;
        end else if (wr_en && (int'(Ctx) == i)) begin
          if (FlagWrite[1]) flags_q[i][3:2] <= ALUFlags[3:2];
          if (FlagWrite[0]) flags_q[i][1:0] <= ALUFlags[1:0];
        end
        if (do_push && (int'(ExcCtx) == i)) begin
          count_q[i] <= count_q[i] + NW'(1);
        end else if (do_pop && (int'(ExcCtx) == i)) begin
          count_q[i] <= count_q[i] - NW'(1);
        end
      end
    end
  end

  // Stack storage carries no reset; the counts define which entries are live.
  always_ff @(posedge clk) begin
    if (!reset && do_push) begin
      stack_q[ExcCtx][push_idx] <= exc_flags;
    end
  end

  // Status flags come straight from the registered counts.
  always_comb begin
    for (int i = 0; i < NCTX; i++) begin
      StackFull[i]  = (count_q[i] == NW'(SDEPTH));
      StackEmpty[i] = (count_q[i] == '0);
    end
    StackErr = err_q;
  end

endmodule

// File: tb/tb_cond_unit_mc.sv
// tb_cond_unit_mc
// Directed bench for cond_unit_mc with NCTX=2, SDEPTH=4. Inputs change one
// time unit after each rising edge. Combinational outputs are checked one
// time unit after the inputs change, which keeps all samples away from the
// clock edge.
module tb_cond_unit_mc;

  logic       clk;
  logic       reset;
  logic       Valid;
  logic       Ctx;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagWrite;
  logic       ExcCtx;
  logic       Save;
  logic       Restore;
  logic       CondEx;
  logic [3:0] FlagsOut;
  logic [1:0] StackFull;
  logic [1:0] StackEmpty;
  logic       StackErr;

  int total;
  int bad;

  cond_unit_mc #(.NCTX(2), .SDEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .Valid      (Valid),
    .Ctx        (Ctx),
    .Cond       (Cond),
    .ALUFlags   (ALUFlags),
    .FlagWrite  (FlagWrite),
    .ExcCtx     (ExcCtx),
    .Save       (Save),
    .Restore    (Restore),
    .CondEx     (CondEx),
    .FlagsOut   (FlagsOut),
    .StackFull  (StackFull),
    .StackEmpty (StackEmpty),
    .StackErr   (StackErr)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode, written out from the condition table with named flag bits.
  function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cc, v;
    n = f[3]; z = f[2]; cc = f[1]; v = f[0];
    case (c)
      0:  return z == 1'b1;
      1:  return z == 1'b0;
      2:  return cc == 1'b1;
      3:  return cc == 1'b0;
      4:  return n == 1'b1;
      5:  return n == 1'b0;
      6:  return v == 1'b1;
      7:  return v == 1'b0;
      8:  return (cc == 1'b1) && (z == 1'b0);
      9:  return (cc == 1'b0) || (z == 1'b1);
      10: return n == v;
      11: return n != v;
      12: return (z == 1'b0) && (n == v);
      13: return (z == 1'b1) || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Single comparison point; every check counts and reports through here.
  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive all control inputs at once, then let the combinational outputs settle.
  task automatic applyStimulus(input logic v, input logic c, input logic [3:0] cd,
                               input logic [1:0] fw, input logic [3:0] alu,
                               input logic e, input logic s, input logic r);
    Valid     = v;
    Ctx       = c;
    Cond      = cd;
    FlagWrite = fw;
    ALUFlags  = alu;
    ExcCtx    = e;
    Save      = s;
    Restore   = r;
    #1;
  endtask

  // Advance to one time unit past the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  // Read the registered flags of a context with no instruction active.
  task automatic checkFlags(input string tag, input logic c, input logic [3:0] exp);
    applyStimulus(1'b0, c, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput(tag, {4'h0, FlagsOut}, {4'h0, exp});
  endtask

  // AL instruction writing all four flags of a context.
  task automatic loadFlags(input logic c, input logic [3:0] f);
    applyStimulus(1'b1, c, 4'hE, 2'b11, f, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;

    // Reset state
    checkFlags("rst_flags0", 1'b0, 4'h0);
    checkFlags("rst_flags1", 1'b1, 4'h0);
    checkOutput("rst_empty", {6'd0, StackEmpty}, 8'h03);
    checkOutput("rst_full",  {6'd0, StackFull},  8'h00);
    checkOutput("rst_err",   {7'd0, StackErr},   8'h00);
    checkOutput("rst_condex_invalid", {7'd0, CondEx}, 8'h00);

    // Basic decode on cleared flags
    applyStimulus(1'b1, 1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("eq_zero_flags", {7'd0, CondEx}, 8'h00);
    applyStimulus(1'b1, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("al_pass", {7'd0, CondEx}, 8'h01);
    applyStimulus(1'b1, 1'b0, 4'hF, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("nv_fail", {7'd0, CondEx}, 8'h00);

    // Valid=0 blocks both CondEx and the write
    applyStimulus(1'b0, 1'b0, 4'hE, 2'b11, 4'hF, 1'b0, 1'b0, 1'b0);
    checkOutput("invalid_condex", {7'd0, CondEx}, 8'h00);
    step();
    checkFlags("invalid_nowrite", 1'b0, 4'h0);

    // NZ-only write on ctx 1
    applyStimulus(1'b1, 1'b1, 4'hE, 2'b10, 4'b0100, 1'b0, 1'b0, 1'b0);
    step();
    checkFlags("nz_write_ctx1", 1'b1, 4'b0100);
    checkFlags("ctx0_untouched", 1'b0, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("eq_ctx1", {7'd0, CondEx}, 8'h01);

    // CV-only write keeps NZ: 0100 with CV<-11 gives 0111
    applyStimulus(1'b1, 1'b1, 4'hE, 2'b01, 4'b1011, 1'b0, 1'b0, 1'b0);
    step();
    checkFlags("cv_write_ctx1", 1'b1, 4'b0111);

    // Condition gating of the flag write
    loadFlags(1'b0, 4'b0100);
    applyStimulus(1'b1, 1'b0, 4'h1, 2'b11, 4'b1011, 1'b0, 1'b0, 1'b0);
    checkOutput("ne_fails", {7'd0, CondEx}, 8'h00);
    step();
    checkFlags("ne_nowrite", 1'b0, 4'b0100);
    applyStimulus(1'b1, 1'b0, 4'h0, 2'b11, 4'b1011, 1'b0, 1'b0, 1'b0);
    checkOutput("eq_passes", {7'd0, CondEx}, 8'h01);
    step();
    checkFlags("eq_write", 1'b0, 4'b1011);

    // Full sweep: 16 flag values x 16 condition codes on ctx 0
    for (int f = 0; f < 16; f++) begin
      loadFlags(1'b0, 4'(f));
      for (int c = 0; c < 16; c++) begin
        applyStimulus(1'b1, 1'b0, 4'(c), 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
        checkOutput($sformatf("sweep_f%0h_c%0h", f, c), {7'd0, CondEx},
                    {7'd0, refCond(4'(c), 4'(f))});
      end
    end

    // Save, overwrite, restore
    loadFlags(1'b0, 4'b1010);
    applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("save_notempty", {6'd0, StackEmpty}, 8'h02);
    loadFlags(1'b0, 4'b0001);
    checkFlags("overwrite", 1'b0, 4'b0001);
    applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkFlags("restore_val", 1'b0, 4'b1010);
    checkOutput("restore_empty", {6'd0, StackEmpty}, 8'h03);
    checkOutput("restore_noerr", {7'd0, StackErr}, 8'h00);

    // Fill the stack with 0001, then overflow with a concurrent write
    loadFlags(1'b0, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
      step();
    end
    checkOutput("full_after4", {6'd0, StackFull}, 8'h01);
    checkOutput("full_noerr", {7'd0, StackErr}, 8'h00);
    applyStimulus(1'b1, 1'b0, 4'hE, 2'b11, 4'b1100, 1'b0, 1'b1, 1'b0);
    step();
    checkOutput("overflow_err", {7'd0, StackErr}, 8'h01);
    checkOutput("overflow_still_full", {6'd0, StackFull}, 8'h01);
    checkFlags("overflow_write_applies", 1'b0, 4'b1100);
    step();
    checkOutput("err_one_cycle", {7'd0, StackErr}, 8'h00);

    // Drain: exactly four pops, each returning 0001
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
      step();
      checkFlags($sformatf("drain_%0d", k), 1'b0, 4'b0001);
    end
    checkOutput("drain_empty", {6'd0, StackEmpty}, 8'h03);
    checkOutput("drain_notfull", {6'd0, StackFull}, 8'h00);

    // Restore on empty stack
    applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1);
    step();
    checkOutput("underflow_err", {7'd0, StackErr}, 8'h01);
    checkFlags("underflow_flags", 1'b0, 4'b0001);
    checkOutput("underflow_empty", {6'd0, StackEmpty}, 8'h03);

    // Save and Restore together with one entry on the stack
    applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("both_err", {7'd0, StackErr}, 8'h01);
    checkOutput("both_nochange_empty", {6'd0, StackEmpty}, 8'h02);
    checkOutput("both_nochange_full", {6'd0, StackFull}, 8'h00);
    checkFlags("both_flags", 1'b0, 4'b0001);

    // Restore wins over a same-context AL write
    loadFlags(1'b0, 4'b1000);
    applyStimulus(1'b1, 1'b0, 4'hE, 2'b11, 4'b1111, 1'b0, 1'b0, 1'b1);
    step();
    checkFlags("restore_wins", 1'b0, 4'b0001);
    checkOutput("restore_wins_empty", {6'd0, StackEmpty}, 8'h03);

    // Restore on ctx 1 alongside a write to ctx 0: both apply
    applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b1, 1'b1, 1'b0);
    step();
    checkOutput("ctx1_pushed", {6'd0, StackEmpty}, 8'h01);
    loadFlags(1'b1, 4'b1110);
    applyStimulus(1'b1, 1'b0, 4'hE, 2'b11, 4'b0110, 1'b1, 1'b0, 1'b1);
    step();
    checkFlags("cross_write_ctx0", 1'b0, 4'b0110);
    checkFlags("cross_restore_ctx1", 1'b1, 4'b0111);
    checkOutput("cross_empty", {6'd0, StackEmpty}, 8'h03);

    // Reset mid-sequence: one push pending, an error pulse live, and a write requested
    applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 4'hE, 2'b00, 4'h0, 1'b0, 1'b1, 1'b1);
    step();
    checkOutput("pre_reset_err", {7'd0, StackErr}, 8'h01);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 4'hE, 2'b11, 4'hF, 1'b1, 1'b1, 1'b0);
    step();
    reset = 1'b0;
    idle();
    checkOutput("mid_rst_err", {7'd0, StackErr}, 8'h00);
    checkOutput("mid_rst_empty", {6'd0, StackEmpty}, 8'h03);
    checkOutput("mid_rst_full", {6'd0, StackFull}, 8'h00);
    checkFlags("mid_rst_flags0", 1'b0, 4'h0);
    checkFlags("mid_rst_flags1", 1'b1, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
